// File: rtl/mem_load_arbiter_pkg.sv
// mem_arb_pkg: shared state encoding and default address width for the download/CPU memory arbiter
package mem_arb_pkg;
  localparam int AW_DEF = 19;
  typedef enum logic [1:0] {IDLE, LOAD, CPU, DONE} state_e;
endpackage

// File: rtl/mem_load_arbiter_if.sv
// mem_load_arbiter_if: download stream, CPU handshake and memory pins seen by the arbiter
interface mem_load_arbiter_if import mem_arb_pkg::*; #(parameter int AW = AW_DEF);
  logic          init;
  logic          iniW;
  logic [AW-1:0] iniA;
  logic [7:0]    iniD;
  logic          cpuReq;
  logic          cpuWe;
  logic [AW-1:0] cpuA;
  logic [7:0]    cpuD;
  logic [7:0]    cpuQ;
  logic          cpuAck;
  logic          memCe;
  logic          memWe;
  logic [AW-1:0] memA;
  logic [7:0]    memD;
  logic [7:0]    memQ;
  logic          busy;
  logic          overflow;
  modport slave (
    input  init, iniW, iniA, iniD, cpuReq, cpuWe, cpuA, cpuD, memQ,
    output cpuQ, cpuAck, memCe, memWe, memA, memD, busy, overflow
  );
  modport master (
    output init, iniW, iniA, iniD, cpuReq, cpuWe, cpuA, cpuD, memQ,
    input  cpuQ, cpuAck, memCe, memWe, memA, memD, busy, overflow
  );
endinterface

// File: rtl/mem_load_arbiter_fifo.sv
// load_fifo: small synchronous FIFO holding pending download {address,data} entries
module load_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 27
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH) + 1;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0]  mem_q [DEPTH];
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[PW-2:0] == rd_q[PW-2:0]);
  assign dout  = mem_q[rd_q[PW-2:0]];
  // next pointers; the extra MSB separates full from empty
  always_comb begin
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
  end
  // pointer registers, cleared by reset so stale entries are discarded
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // storage is not reset; a full-and-pop push overwrites the slot being read out this cycle
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q[PW-2:0]] <= din;
  end
endmodule

// File: rtl/mem_load_arbiter.sv
// mem_load_arbiter: shares one memory between the buffered ROM download and CPU req/ack accesses
module mem_load_arbiter import mem_arb_pkg::*; #(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = 4,
  parameter int WAIT  = 1
) (
  input logic               clock,
  input logic               reset,
  mem_load_arbiter_if.slave b
);
  localparam logic [2:0] LAST = 3'(WAIT);
  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          mem_ce_q, mem_ce_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [7:0]    mem_d_q, mem_d_d, cpu_q_q, cpu_q_d;
  logic          cpu_ack_q, cpu_ack_d, overflow_q, overflow_d;
  logic          push, pop, full, empty;
  logic [AW+7:0] head;
  load_fifo #(.DEPTH(DEPTH), .W(AW + 8)) u_fifo (
    .clock(clock), .reset(reset), .push(push), .pop(pop),
    .din({b.iniA, b.iniD}), .dout(head), .full(full), .empty(empty)
  );
  // arbitration: pending download bytes always win; a granted CPU access runs to completion
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 3'd1;
    mem_ce_d   = mem_ce_q;
    mem_we_d   = mem_we_q;
    mem_a_d    = mem_a_q;
    mem_d_d    = mem_d_q;
    cpu_q_d    = cpu_q_q;
    cpu_ack_d  = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE:
        if (!empty) begin
          pop                = 1'b1;
          state_d            = LOAD;
          cnt_d              = '0;
          mem_ce_d           = 1'b1;
          mem_we_d           = 1'b1;
          {mem_a_d, mem_d_d} = head;
        end else if (b.init && b.cpuReq) begin
          state_d  = CPU;
          cnt_d    = '0;
          mem_ce_d = 1'b1;
          mem_we_d = b.cpuWe;
          mem_a_d  = b.cpuA;
          mem_d_d  = b.cpuD;
        end
      LOAD:
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (!empty) begin
            pop                = 1'b1;
            {mem_a_d, mem_d_d} = head;
          end else begin
            state_d  = IDLE;
            mem_ce_d = 1'b0;
            mem_we_d = 1'b0;
          end
        end
      CPU:
        if (cnt_q == LAST) begin
          state_d   = DONE;
          mem_ce_d  = 1'b0;
          mem_we_d  = 1'b0;
          cpu_q_d   = b.memQ;
          cpu_ack_d = 1'b1;
        end
      default: state_d = IDLE;
    endcase
    push       = b.iniW && (!full || pop);
    overflow_d = overflow_q || (b.iniW && full && !pop);
  end
  // state, wait counter and all registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_ce_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_d_q    <= '0;
      cpu_q_q    <= '0;
      cpu_ack_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_ce_q   <= mem_ce_d;
      mem_we_q   <= mem_we_d;
      mem_a_q    <= mem_a_d;
      mem_d_q    <= mem_d_d;
      cpu_q_q    <= cpu_q_d;
      cpu_ack_q  <= cpu_ack_d;
      overflow_q <= overflow_d;
    end
  end
  assign b.memCe    = mem_ce_q;
  assign b.memWe    = mem_we_q;
  assign b.memA     = mem_a_q;
  assign b.memD     = mem_d_q;
  assign b.cpuQ     = cpu_q_q;
  assign b.cpuAck   = cpu_ack_q;
  assign b.overflow = overflow_q;
  assign b.busy     = !b.init || !empty;
endmodule

// File: tb/tb_mem_load_arbiter.sv
// tb_mem_load_arbiter: directed vectors and corner-case sequences for mem_load_arbiter
module tb_mem_load_arbiter;
  localparam int W = 2;
  typedef struct {
    logic        we;
    logic [18:0] a;
    logic [7:0]  d;
    logic [7:0]  q;
    logic [7:0]  exp_q;
  } vec_t;
  logic clock = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;
  logic [18:0] log_a[$];
  logic [7:0]  log_d[$];
  int          run = 0;
  logic [26:0] last = '0;
  vec_t vecs[5];
  mem_load_arbiter_if #(.AW(19)) b ();
  mem_load_arbiter #(.AW(19), .DEPTH(4), .WAIT(W)) dut (.clock(clock), .reset(reset), .b(b));
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  always @(negedge clock) begin
    if (b.memCe && b.memWe && run > 0 && run < W + 1 && {b.memA, b.memD} == last) run++;
    else begin
      if (run > 0) chk("write_len", run, W + 1);
      run = 0;
      if (b.memCe && b.memWe) begin
        log_a.push_back(b.memA);
        log_d.push_back(b.memD);
        last = {b.memA, b.memD};
        run = 1;
      end
    end
  end
  task automatic cpu_access(input vec_t v);
    int lat, ce, bad;
    lat = 0;
    ce  = 0;
    bad = 0;
    b.cpuReq = 1'b1;
    b.cpuWe  = v.we;
    b.cpuA   = v.a;
    b.cpuD   = v.d;
    b.memQ   = v.q;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      tick(1);
      if (b.memCe) begin
        ce++;
        if (b.memA !== v.a || b.memWe !== v.we || (v.we && b.memD !== v.d)) bad++;
      end
      if (b.cpuAck) lat = k;
    end
    b.cpuReq = 1'b0;
    chk("cpu_latency", lat, W + 2);
    chk("cpu_ce_cycles", ce, W + 1);
    chk("cpu_bus", bad, 0);
    if (!v.we) chk("cpu_q", b.cpuQ, v.exp_q);
    tick(1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int cpu_ce, acks, early;
    logic [7:0] ed;
    int idx[7];
    vecs[0] = '{1'b0, 19'h01234, 8'h00, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 19'h01234, 8'h5A, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 19'h7FFFF, 8'h00, 8'h3C, 8'h3C};
    vecs[3] = '{1'b1, 19'h00000, 8'hFF, 8'h11, 8'h11};
    vecs[4] = '{1'b0, 19'h40001, 8'h00, 8'h00, 8'h00};
    idx = '{0, 1, 2, 3, 4, 5, 7};
    reset = 1'b1;
    b.init = 1'b1; b.iniW = 1'b0; b.iniA = '0; b.iniD = '0;
    b.cpuReq = 1'b0; b.cpuWe = 1'b0; b.cpuA = '0; b.cpuD = '0; b.memQ = '0;
    #12;
    chk("rst_memCe", b.memCe, 0);
    chk("rst_memWe", b.memWe, 0);
    chk("rst_memA", b.memA, 0);
    chk("rst_memD", b.memD, 0);
    chk("rst_cpuQ", b.cpuQ, 0);
    chk("rst_cpuAck", b.cpuAck, 0);
    chk("rst_overflow", b.overflow, 0);
    chk("rst_busy", b.busy, 0);
    tick(1);
    reset = 1'b0;
    tick(2);
    for (int i = 0; i < 5; i++) cpu_access(vecs[i]);
    chk("cpu_wr_log_n", log_a.size(), 2);
    if (log_a.size() == 2) begin
      chk("cpu_wr0_a", log_a[0], 19'h01234);
      chk("cpu_wr0_d", log_d[0], 8'h5A);
      chk("cpu_wr1_d", log_d[1], 8'hFF);
    end
    // request held across ack restarts a new access two cycles later
    b.cpuReq = 1'b1; b.cpuWe = 1'b0; b.cpuA = 19'h01111; b.memQ = 8'h12;
    tick(W + 2);
    chk("rehold_ack1", b.cpuAck, 1);
    tick(2);
    chk("rehold_ce", b.memCe, 1);
    chk("rehold_a", b.memA, 19'h01111);
    tick(W + 1);
    chk("rehold_ack2", b.cpuAck, 1);
    b.cpuReq = 1'b0;
    tick(2);
    // 16-byte download, one byte every 4 cycles
    log_a.delete(); log_d.delete();
    b.init = 1'b0;
    #0 chk("dl_busy", b.busy, 1);
    for (int i = 0; i < 16; i++) begin
      b.iniA = 19'h00100 + 19'(i);
      b.iniD = 8'(8'h30 + i * 7);
      b.iniW = 1'b1;
      tick(1);
      b.iniW = 1'b0;
      tick(3);
    end
    b.init = 1'b1;
    tick(8);
    chk("dl_count", log_a.size(), 16);
    for (int i = 0; i < 16 && i < log_a.size(); i++) begin
      ed = 8'(8'h30 + i * 7);
      chk("dl_addr", log_a[i], 19'h00100 + 19'(i));
      chk("dl_data", log_d[i], ed);
    end
    chk("dl_overflow", b.overflow, 0);
    chk("dl_busy_end", b.busy, 0);
    // byte and CPU request together: CPU first, byte afterwards
    log_a.delete(); log_d.delete();
    b.memQ = 8'h66; b.cpuReq = 1'b1; b.cpuWe = 1'b0; b.cpuA = 19'h02222;
    b.iniW = 1'b1; b.iniA = 19'h03333; b.iniD = 8'h77;
    tick(1);
    b.iniW = 1'b0;
    chk("sim_ce", b.memCe, 1);
    chk("sim_a", b.memA, 19'h02222);
    chk("sim_we", b.memWe, 0);
    chk("sim_busy", b.busy, 1);
    tick(W + 1);
    chk("sim_ack", b.cpuAck, 1);
    chk("sim_q", b.cpuQ, 8'h66);
    b.cpuReq = 1'b0;
    tick(7);
    chk("sim_log_n", log_a.size(), 1);
    if (log_a.size() == 1) begin
      chk("sim_log_a", log_a[0], 19'h03333);
      chk("sim_log_d", log_d[0], 8'h77);
    end
    // CPU held off by init=0 and a non-empty FIFO
    log_a.delete(); log_d.delete();
    b.init = 1'b0;
    b.cpuReq = 1'b1; b.cpuWe = 1'b1; b.cpuA = 19'h04444; b.cpuD = 8'h99;
    b.iniW = 1'b1; b.iniA = 19'h00500; b.iniD = 8'hE1;
    tick(1);
    b.iniA = 19'h00501; b.iniD = 8'hE2;
    tick(1);
    b.iniW = 1'b0;
    cpu_ce = 0; acks = 0; early = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 6) b.init = 1'b1;
      tick(1);
      if (b.memCe && b.memA == 19'h04444) begin
        cpu_ce++;
        if (!b.init) early++;
      end
      if (b.cpuAck) begin
        acks++;
        b.cpuReq = 1'b0;
      end
    end
    chk("blk_early", early, 0);
    chk("blk_ce", cpu_ce, W + 1);
    chk("blk_acks", acks, 1);
    chk("blk_log_n", log_a.size(), 3);
    if (log_a.size() == 3) begin
      chk("blk_log0", log_a[0], 19'h00500);
      chk("blk_log1", log_a[1], 19'h00501);
      chk("blk_log2", log_a[2], 19'h04444);
      chk("blk_logd2", log_d[2], 8'h99);
    end
    // 8-cycle burst into a 4-deep FIFO: byte 6 dropped
    log_a.delete(); log_d.delete();
    b.init = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b.iniA = 19'h00600 + 19'(i);
      b.iniD = 8'hC0 + 8'(i);
      b.iniW = 1'b1;
      tick(1);
    end
    b.iniW = 1'b0;
    chk("ovf_set", b.overflow, 1);
    tick(25);
    b.init = 1'b1;
    #0 chk("ovf_count", log_a.size(), 7);
    for (int i = 0; i < 7 && i < log_a.size(); i++) begin
      chk("ovf_addr", log_a[i], 19'h00600 + 19'(idx[i]));
      chk("ovf_data", log_d[i], 8'hC0 + 8'(idx[i]));
    end
    chk("ovf_sticky", b.overflow, 1);
    chk("ovf_busy", b.busy, 0);
    // asynchronous reset in the second cycle of a CPU read
    b.memQ = 8'h42; b.cpuReq = 1'b1; b.cpuWe = 1'b0; b.cpuA = 19'h00ABC;
    tick(1);
    chk("rr_ce1", b.memCe, 1);
    tick(1);
    #2 reset = 1'b1;
    #1;
    chk("rr_ce", b.memCe, 0);
    chk("rr_a", b.memA, 0);
    chk("rr_ack", b.cpuAck, 0);
    chk("rr_ovf", b.overflow, 0);
    b.cpuReq = 1'b0;
    tick(2);
    reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      if (b.cpuAck) acks++;
    end
    chk("rr_no_ack", acks, 0);
    cpu_access('{1'b0, 19'h00DEF, 8'h00, 8'h81, 8'h81});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
